// File: rtl/conv_layer_seq.sv
// conv_layer_seq: per-layer sequencer for the 3x3 conv engine.
// For each channel it loads weights, triggers the engine and commits output pixels. Rev 1.0
`default_nettype none
`timescale 1ns/1ps

module conv_layer_seq #(
  parameter int NUM_CH_MAX = 10,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_AW     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_layer,
  input  logic [4:0]            i_in_w,
  input  logic [4:0]            i_in_h,
  input  logic [3:0]            i_num_ch,
  output logic                  o_wld_req,
  output logic [3:0]            o_wld_chan,
  input  logic                  i_wld_ack,
  output logic                  o_conv_trigger,
  output logic [3:0]            o_conv_chan,
  output logic                  o_conv_layer,
  input  logic                  i_conv_valid,
  input  logic                  i_conv_done,
  input  logic [DATA_WIDTH-1:0] i_conv_pixel,
  input  logic [7:0]            i_conv_addr,
  output logic                  o_save_done,
  output logic                  o_om_we,
  output logic [OUT_AW-1:0]     o_om_addr,
  output logic [DATA_WIDTH-1:0] o_om_wdata,
  output logic                  o_busy,
  output logic                  o_layer_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_TRIG = 3'd2,
    S_RUN  = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t                r_state;
  logic [3:0]            r_chan;
  logic                  r_layer;
  logic [4:0]            r_in_w;
  logic [4:0]            r_in_h;
  logic [3:0]            r_num_ch;
  logic [7:0]            r_pix_cnt;
  logic                  r_wld_req;
  logic                  r_trig;
  logic                  r_save_done;
  logic                  r_om_we;
  logic [OUT_AW-1:0]     r_om_addr;
  logic [DATA_WIDTH-1:0] r_om_wdata;
  logic                  r_busy;
  logic                  r_layer_done;
  logic                  r_err;

  logic       w_cfg_bad;
  logic [4:0] w_w2;
  logic [4:0] w_h2;
  logic [7:0] w_exp_cnt;

  assign w_cfg_bad = (i_num_ch == 4'd0) || (i_num_ch > 4'(NUM_CH_MAX)) ||
                     (i_in_w < 5'd3) || (i_in_h < 5'd3);
  assign w_w2      = r_in_w - 5'd2;
  assign w_h2      = r_in_h - 5'd2;
  // Valid-pixel count per plane, deliberately kept to 8 bits like r_pix_cnt.
  assign w_exp_cnt = {3'd0, w_h2} * {3'd0, w_w2};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_chan       <= 4'd0;
      r_layer      <= 1'b0;
      r_in_w       <= 5'd0;
      r_in_h       <= 5'd0;
      r_num_ch     <= 4'd0;
      r_pix_cnt    <= 8'd0;
      r_wld_req    <= 1'b0;
      r_trig       <= 1'b0;
      r_save_done  <= 1'b0;
      r_om_we      <= 1'b0;
      r_om_addr    <= '0;
      r_om_wdata   <= '0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_trig       <= 1'b0;
      r_save_done  <= 1'b0;
      r_om_we      <= 1'b0;
      r_layer_done <= 1'b0;
      if (i_conv_valid && (r_state != S_RUN)) r_err <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_layer  <= i_layer;
            r_in_w   <= i_in_w;
            r_in_h   <= i_in_h;
            r_num_ch <= i_num_ch;
            r_chan   <= 4'd0;
            r_busy   <= 1'b1;
            r_err    <= w_cfg_bad && (i_num_ch != 4'd0);
            if (w_cfg_bad) begin
              r_state <= S_DONE;
            end else begin
              r_wld_req <= 1'b1;
              r_state   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (i_wld_ack) begin
            r_wld_req <= 1'b0;
            r_trig    <= 1'b1;
            r_state   <= S_TRIG;
          end
        end
        S_TRIG: begin
          r_pix_cnt <= 8'd0;
          r_state   <= S_RUN;
        end
        S_RUN: begin
          if (i_conv_valid) begin
            r_om_we     <= 1'b1;
            r_om_addr   <= OUT_AW'({r_chan, i_conv_addr});
            r_om_wdata  <= i_conv_pixel;
            r_pix_cnt   <= r_pix_cnt + 8'd1;
            r_save_done <= !i_conv_done;
            if (i_conv_done) r_state <= S_NEXT;
          end else if (i_conv_done) begin
            r_err   <= 1'b1;
            r_state <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (r_pix_cnt != w_exp_cnt) r_err <= 1'b1;
          if (r_chan == r_num_ch - 4'd1) begin
            r_layer_done <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_chan    <= r_chan + 4'd1;
            r_wld_req <= 1'b1;
            r_state   <= S_LOAD;
          end
        end
        S_DONE: begin
          // Entered with the pulse already up from NEXT; the config-error path raises it here.
          if (r_layer_done) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_layer_done <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wld_req      = r_wld_req;
  assign o_wld_chan     = r_chan;
  assign o_conv_trigger = r_trig;
  assign o_conv_chan    = r_chan;
  assign o_conv_layer   = r_layer;
  assign o_save_done    = r_save_done;
  assign o_om_we        = r_om_we;
  assign o_om_addr      = r_om_addr;
  assign o_om_wdata     = r_om_wdata;
  assign o_busy         = r_busy;
  assign o_layer_done   = r_layer_done;
  assign o_err          = r_err;

endmodule

`default_nettype wire

// File: tb/tb_conv_layer_seq.sv
// tb_conv_layer_seq: directed bench with an engine/loader model and a write scoreboard.
`default_nettype none
`timescale 1ns/1ps

module tb_conv_layer_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_start = 1'b0, i_layer = 1'b0;
  logic [4:0]  i_in_w = 5'd0, i_in_h = 5'd0;
  logic [3:0]  i_num_ch = 4'd0;
  logic        o_wld_req;
  logic [3:0]  o_wld_chan;
  logic        i_wld_ack = 1'b0;
  logic        o_conv_trigger;
  logic [3:0]  o_conv_chan;
  logic        o_conv_layer;
  logic        i_conv_valid = 1'b0, i_conv_done = 1'b0;
  logic [7:0]  i_conv_pixel = 8'd0, i_conv_addr = 8'd0;
  logic        o_save_done, o_om_we;
  logic [11:0] o_om_addr;
  logic [7:0]  o_om_wdata;
  logic        o_busy, o_layer_done, o_err;

  conv_layer_seq #(.NUM_CH_MAX(10), .DATA_WIDTH(8), .OUT_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_layer(i_layer),
    .i_in_w(i_in_w), .i_in_h(i_in_h), .i_num_ch(i_num_ch),
    .o_wld_req(o_wld_req), .o_wld_chan(o_wld_chan), .i_wld_ack(i_wld_ack),
    .o_conv_trigger(o_conv_trigger), .o_conv_chan(o_conv_chan), .o_conv_layer(o_conv_layer),
    .i_conv_valid(i_conv_valid), .i_conv_done(i_conv_done),
    .i_conv_pixel(i_conv_pixel), .i_conv_addr(i_conv_addr),
    .o_save_done(o_save_done), .o_om_we(o_om_we), .o_om_addr(o_om_addr),
    .o_om_wdata(o_om_wdata), .o_busy(o_busy), .o_layer_done(o_layer_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [11:0] addr;
    logic [7:0]  data;
    logic        save;
  } wr_t;

  wr_t wq[$];
  int  cyc = 0;
  int  n_checks = 0, n_err = 0;
  int  n_wr, n_save, n_trig, n_ld;
  int  first_addr, last_addr;
  int  exp_trig = -1, exp_ld = -1;
  int  eng_n = 0, eng_ch_cnt = 0, cfg_num = 0, ack_delay = 0;
  logic cfg_layer = 1'b0;
  logic chk_on = 1'b0, abort = 1'b0, stray_req = 1'b0;
  logic prev_req = 1'b0, prev_ack = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Weight loader: ack tied high, or raised on the ack_delay-th cycle of a request.
  initial begin : loader
    int age;
    age = 0;
    forever begin
      @(posedge clk); #1;
      if (ack_delay == 0) i_wld_ack = 1'b1;
      else if (o_wld_req) begin
        age++;
        i_wld_ack = (age >= ack_delay);
      end else begin
        age = 0;
        i_wld_ack = 1'b0;
      end
    end
  end

  // Engine: after each trigger emits eng_n pixels (gap after every 4th), last one flagged done.
  initial begin : engine
    forever begin
      @(negedge clk); #1;
      if (stray_req) begin
        @(posedge clk); #1;
        i_conv_valid = 1'b1; i_conv_done = 1'b0; i_conv_pixel = 8'hA5; i_conv_addr = 8'h11;
        @(posedge clk); #1;
        i_conv_valid = 1'b0; stray_req = 1'b0;
      end else if (o_conv_trigger && rst_n) begin : run_ch
        int ch;
        wr_t e;
        ch = eng_ch_cnt;
        eng_ch_cnt++;
        for (int i = 0; i < eng_n; i++) begin
          @(posedge clk); #1;
          if (abort) begin
            i_conv_valid = 1'b0; i_conv_done = 1'b0;
            break;
          end
          i_conv_valid = 1'b1;
          i_conv_done  = (i == eng_n - 1);
          i_conv_addr  = i[7:0];
          i_conv_pixel = 8'((ch * 37 + i * 5 + 3) % 256);
          e.due  = cyc + 1;
          e.addr = {ch[3:0], i[7:0]};
          e.data = i_conv_pixel;
          e.save = !i_conv_done;
          wq.push_back(e);
          if (i_conv_done && ch == cfg_num - 1) exp_ld = cyc + 2;
          if (i % 4 == 3) begin
            @(posedge clk); #1;
            i_conv_valid = 1'b0; i_conv_done = 1'b0;
          end
        end
        @(posedge clk); #1;
        i_conv_valid = 1'b0; i_conv_done = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the scoreboard and handshake rules.
  always @(negedge clk) begin
    if (chk_on) begin
      if (wq.size() > 0 && wq[0].due == cyc) begin
        chk("om_we", o_om_we, 1);
        chk("om_addr", o_om_addr, wq[0].addr);
        chk("om_wdata", o_om_wdata, wq[0].data);
        chk("save_done", o_save_done, wq[0].save);
        void'(wq.pop_front());
      end else begin
        chk("no_write", {o_om_we, o_save_done}, 0);
      end
      chk("conv_trigger", o_conv_trigger, (cyc == exp_trig));
      chk("layer_done", o_layer_done, (cyc == exp_ld));
      if (prev_req && !prev_ack) chk("wld_req_hold", o_wld_req, 1);
      if (o_wld_req) chk("wld_chan", o_wld_chan, eng_ch_cnt);
      if (o_conv_trigger) begin
        chk("conv_chan", o_conv_chan, eng_ch_cnt);
        chk("conv_layer", o_conv_layer, cfg_layer);
      end
      if (o_wld_req && i_wld_ack) exp_trig = cyc + 1;
      if (o_om_we) begin
        if (n_wr == 0) first_addr = o_om_addr;
        last_addr = o_om_addr;
        n_wr++;
      end
      if (o_save_done) n_save++;
      if (o_conv_trigger) n_trig++;
      if (o_layer_done) n_ld++;
      prev_req = o_wld_req;
      prev_ack = i_wld_ack;
    end
  end

  task automatic do_start(input logic lay, input int w, input int h, input int n,
                          input int shrt, input int dly);
    logic bad;
    bad = (n == 0) || (n > 10) || (w < 3) || (h < 3);
    @(posedge clk); #1;
    n_wr = 0; n_save = 0; n_trig = 0; n_ld = 0; eng_ch_cnt = 0; abort = 1'b0;
    first_addr = -1; last_addr = -1;
    cfg_layer = lay; cfg_num = n; ack_delay = dly;
    eng_n = bad ? 0 : (h - 2) * (w - 2) - shrt;
    exp_ld = bad ? cyc + 2 : -1;
    i_layer = lay; i_in_w = w[4:0]; i_in_h = h[4:0]; i_num_ch = n[3:0];
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("busy_after_start", o_busy, 1);
    chk("wld_req_after_start", o_wld_req, !bad);
    chk("err_after_start", o_err, bad && (n != 0));
  endtask

  task automatic wait_ld(input int budget);
    int c;
    c = 0;
    while (n_ld == 0 && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("layer_done_seen", (n_ld != 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ch(input int target, input int budget);
    int c;
    c = 0;
    while (eng_ch_cnt < target && c < budget) begin
      @(negedge clk); #2;
      c++;
    end
    chk("channel_reached", (eng_ch_cnt >= target), 1);
  endtask

  initial begin
    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs_a", {o_wld_req, o_wld_chan, o_conv_trigger, o_conv_chan, o_conv_layer,
                       o_save_done, o_om_we, o_busy, o_layer_done, o_err}, 0);
    chk("rst_outs_b", {o_om_addr, o_om_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; chk_on = 1'b1;

    // 5x5, one channel, ack tied high.
    do_start(1'b0, 5, 5, 1, 0, 0);
    wait_ld(200);
    chk("small_writes", n_wr, 9);
    chk("small_saves", n_save, 8);
    chk("small_first_addr", first_addr, 12'h000);
    chk("small_last_addr", last_addr, 12'h008);
    chk("small_ld_count", n_ld, 1);
    chk("small_err", o_err, 0);
    chk("small_busy_end", o_busy, 0);

    // Full conv1: 10 channels of 14x13 outputs.
    do_start(1'b0, 15, 16, 10, 0, 0);
    wait_ld(4000);
    chk("full_writes", n_wr, 1820);
    chk("full_saves", n_save, 1810);
    chk("full_triggers", n_trig, 10);
    chk("full_last_addr", last_addr, 12'h9B5);
    chk("full_err", o_err, 0);

    // Weight-load stall on conv2.
    do_start(1'b1, 5, 5, 3, 0, 7);
    wait_ld(500);
    chk("stall_triggers", n_trig, 3);
    chk("stall_writes", n_wr, 27);
    chk("stall_err", o_err, 0);
    ack_delay = 0;

    // Stray pixel while idle.
    stray_req = 1'b1;
    begin : stray_wait
      int c;
      c = 0;
      while (stray_req && c < 20) begin
        @(negedge clk);
        c++;
      end
    end
    chk("stray_err", o_err, 1);

    // Width below kernel size, then zero channels (which also clears err).
    do_start(1'b0, 2, 5, 2, 0, 0);
    wait_ld(20);
    chk("narrow_triggers", n_trig, 0);
    chk("narrow_err", o_err, 1);
    do_start(1'b0, 5, 5, 0, 0, 0);
    wait_ld(20);
    chk("zero_ch_triggers", n_trig, 0);
    chk("zero_ch_err", o_err, 0);

    // Engine ends a 3x3 channel one pixel early.
    do_start(1'b0, 5, 5, 1, 1, 0);
    wait_ld(200);
    chk("short_writes", n_wr, 8);
    chk("short_err", o_err, 1);

    // Start while busy must not disturb the latched layer.
    do_start(1'b1, 5, 5, 3, 0, 0);
    wait_ch(2, 200);
    @(posedge clk); #1;
    i_start = 1'b1; i_in_w = 5'd9; i_num_ch = 4'd1; i_layer = 1'b0;
    @(posedge clk); #1;
    i_start = 1'b0;
    wait_ld(500);
    chk("busy_start_triggers", n_trig, 3);
    chk("busy_start_writes", n_wr, 27);
    chk("busy_start_err", o_err, 0);

    // Reset pulse during RUN of channel 4.
    do_start(1'b0, 5, 5, 6, 0, 0);
    wait_ch(5, 500);
    repeat (4) @(negedge clk);
    @(posedge clk); #1;
    abort = 1'b1; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    wq.delete(); exp_trig = -1; exp_ld = -1; prev_req = 1'b0;
    @(negedge clk);
    chk("midrst_outs_a", {o_wld_req, o_wld_chan, o_conv_trigger, o_conv_chan, o_conv_layer,
                          o_save_done, o_om_we, o_busy, o_layer_done, o_err}, 0);
    chk("midrst_outs_b", {o_om_addr, o_om_wdata}, 0);
    repeat (20) @(negedge clk);
    chk("midrst_no_ld", n_ld, 0);
    chk("midrst_err", o_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/conv_layer_seq.md
# conv_layer_seq

Layer-level sequencer for the single-channel 3x3 convolution engine. For each output channel of a layer it:
- fetches that channel's weights via a load handshake,
- fires the engine's trigger,
- commits every output pixel to the output feature-map memory,
- returns the per-pixel `save_done` acknowledge.

It sits between the top-level NPU controller, the weight loader, the conv engine and the output buffer, and raises `layer_done` when all channels are written.

## Interface
Parameters:
- NUM_CH_MAX, 10, largest channel count accepted
- DATA_WIDTH, 8, pixel width
- OUT_AW, 12, output memory address width, {chan[3:0], addr[7:0]}

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; starts a layer (ignored unless idle)
- layer  in  1  0 = conv1, 1 = conv2; latched at start
- in_w, in_h  in  5 each  input plane size; latched at start
- num_ch  in  4  channels to process; latched at start
- wld_req  out  1  weight load request, held until ack
- wld_chan  out  4  channel whose weights to load
- wld_ack  in  1  weights for wld_chan present on engine weight bus
- conv_trigger  out  1  one-cycle start to engine
- conv_chan  out  4  current channel to engine
- conv_layer  out  1  latched layer to engine
- conv_valid  in  1  engine pixel valid
- conv_done  in  1  engine last-pixel flag
- conv_pixel  in  DATA_WIDTH  engine pixel
- conv_addr  in  8  engine pixel address within plane
- save_done  out  1  one-cycle pixel acknowledge to engine
- om_we  out  1  output memory write enable
- om_addr  out  OUT_AW  {chan, conv_addr}
- om_wdata  out  DATA_WIDTH  pixel
- busy  out  1  high from the cycle after an accepted start until layer_done
- layer_done  out  1  one-cycle completion pulse
- err  out  1  sticky error; cleared by the next accepted start

## Operation
- States:
  - IDLE: on start, latch config, clear err, chan = 0.
    - num_ch == 0, num_ch > NUM_CH_MAX, in_w < 3 or in_h < 3: set err (except num_ch == 0), go to DONE.
    - Otherwise go to LOAD.
  - LOAD: wld_req = 1 and wld_chan = chan. When wld_ack is sampled high, go to TRIG.
  - TRIG: conv_trigger = 1 for exactly this cycle; clear pix_cnt; go to RUN.
  - RUN: for each conv_valid:
    - capture pixel and address;
    - next cycle: om_we = 1, om_addr = {chan, conv_addr}, om_wdata = conv_pixel;
    - pix_cnt += 1;
    - if conv_done was not high with that conv_valid, save_done = 1 in the same cycle as om_we.
    - conv_valid together with conv_done: no save_done; go to NEXT.
  - NEXT: check pix_cnt == (in_h-2)*(in_w-2), else set err. If chan == num_ch-1, go to DONE; else chan += 1 and go to LOAD.
  - DONE: layer_done = 1 for one cycle; go to IDLE.
- pix_cnt is 8 bits. The expected count is computed with 5-bit operands into an 8-bit product; max 14*13 = 182.
- conv_valid seen in any state other than RUN: set err; no write, no save_done.
- conv_done without conv_valid: set err; treat as end of channel.
- start while busy: ignored; the latched config does not change.
- wld_ack outside LOAD: ignored.

## Timing
- Reset values: all outputs 0, state IDLE, chan 0.
  - Reset mid-layer aborts immediately: no layer_done, no further writes.
- Start handshake:
  - start sampled at cycle 0 → busy = 1 and wld_req = 1 at cycle 1.
  - wld_ack sampled at cycle n → conv_trigger at n+1.
- Pixel write latency: exactly 1 cycle after conv_valid; save_done is coincident with om_we.
- Last-pixel path, with conv_valid&conv_done at cycle t:
  - t+1: write, state NEXT.
  - t+2: wld_req for the next channel, or layer_done.
- The next conv_trigger is therefore never earlier than t+3, so the engine is back in its idle state before it is retriggered.
- All outputs are registered; no combinational input-to-output paths.

## Test plan
- Reset: hold rst_n low 3 cycles → all outputs 0.
  - Then start with in_w = 5, in_h = 5, num_ch = 1, wld_ack tied high, engine model attached → 9 writes to om_addr 0x000–0x008, 8 save_done pulses, layer_done once, err = 0.
- Full conv1: in_w = 15, in_h = 16, num_ch = 10.
  - → 182 writes per channel, om_addr high nibble 0..9.
  - → 10 wld_req/conv_trigger pairs.
  - → layer_done exactly 1 cycle after the channel-9 write.
- Weight-load stall: wld_ack delayed 7 cycles each channel → conv_trigger exactly 1 cycle after each ack; wld_req held until ack.
- Config errors:
  - num_ch = 0 → layer_done 2 cycles after start, no triggers, err = 0.
  - in_w = 2 → err = 1, no triggers.
- Protocol errors:
  - Engine model ends a 3x3-output channel after 8 pixels → err = 1 in NEXT.
  - Stray conv_valid while in IDLE → err = 1, no om_we.
- Mid-layer reset and busy start:
  - rst_n pulsed during RUN of channel 4 → outputs 0 next cycle, no layer_done.
  - start asserted while busy → no effect on the latched config.
